// File: rtl/opt_decryptor_if.sv
// rtl/opt_decryptor_if.sv - ciphertext-in / plaintext-out handshake bundle
interface opt_decryptor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // Producer of ciphertext and consumer of plaintext.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // The decryptor itself.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/opt_decryptor.sv
// rtl/opt_decryptor.sv - streaming byte decryptor with Johnson-counter keystream
module opt_decryptor #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] KS_SEED = '0,
   parameter int               COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_load,
   input  logic [WIDTH-1:0]   key_in,
   opt_decryptor_if.slave     bus,
   output logic               running,
   output logic [COUNT_W-1:0] byte_count
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   key_q, key_d;
   logic [WIDTH-1:0]   ks_q, ks_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               in_ready;
   logic               accept;
   logic [WIDTH-1:0]   diff;

   // Next-state logic: key load beats any incoming byte; the output register
   // refills on accept, empties on drain, and otherwise holds.
   always_comb begin
      in_ready    = (state_q == RUN) && !key_load && (!out_valid_q || bus.out_ready);
      accept      = bus.in_valid && in_ready;
      diff        = bus.in_data - ks_q;
      state_d     = state_q;
      key_d       = key_q;
      ks_d        = ks_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (key_load) begin
         key_d   = key_in;
         ks_d    = KS_SEED;
         count_d = '0;
         state_d = RUN;
      end
      if (accept) begin
         out_data_d  = diff ^ key_q;
         out_valid_d = 1'b1;
         ks_d        = {ks_q[WIDTH-2:0], ~ks_q[WIDTH-1]};
         count_d     = count_q + 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any pending plaintext.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= IDLE;
         key_q       <= '0;
         ks_q        <= KS_SEED;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         ks_q        <= ks_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign running       = (state_q == RUN);
   assign byte_count    = count_q;
endmodule

// File: tb/tb_opt_decryptor.sv
// tb/tb_opt_decryptor.sv - directed scoreboard bench for opt_decryptor
module tb_opt_decryptor;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       key_load = 1'b0;
   logic [7:0] key_in = 8'h00;
   logic       running;
   logic [3:0] byte_count;

   opt_decryptor_if #(.WIDTH(8)) bif ();

   opt_decryptor #(.WIDTH(8), .KS_SEED(8'h00), .COUNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .key_in     (key_in),
      .bus        (bif),
      .running    (running),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] key_m = 8'h00;
   logic [7:0] ks_m = 8'h00;
   logic [3:0] cnt_m = 4'h0;
   logic       run_m = 1'b0;
   logic [7:0] t3 [17];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: called just after a falling edge with inputs already driven.
   task automatic step(input logic exp_ready);
      logic       acc;
      logic [7:0] e;
      #1;
      chk("in_ready", {31'b0, bif.in_ready}, {31'b0, exp_ready});
      acc = bif.in_valid && exp_ready;
      if (bif.out_valid && bif.out_ready && !rst_n) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data_drain", {24'b0, bif.out_data}, {24'b0, e});
         end
      end
      @(posedge clk);
      if (rst_n) begin
         exp_q.delete();
         key_m = 8'h00; ks_m = 8'h00; cnt_m = 4'h0; run_m = 1'b0;
      end else if (key_load) begin
         key_m = key_in; ks_m = 8'h00; cnt_m = 4'h0; run_m = 1'b1;
      end else if (acc) begin
         exp_q.push_back((bif.in_data - ks_m) ^ key_m);
         ks_m  = {ks_m[6:0], ~ks_m[7]};
         cnt_m = cnt_m + 4'h1;
      end
      @(negedge clk);
      chk("byte_count", {28'b0, byte_count}, {28'b0, cnt_m});
      chk("running", {31'b0, running}, {31'b0, run_m});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      t3 = '{8'h00, 8'hFF, 8'hFD, 8'hF9, 8'hF1, 8'hE1, 8'hC1, 8'h81,
             8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
      bif.in_valid = 1'b0; bif.in_data = 8'h00; bif.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bif.out_valid}, 32'd0);
      chk("rst_out_data", {24'b0, bif.out_data}, 32'h00);
      chk("rst_in_ready", {31'b0, bif.in_ready}, 32'd0);
      chk("rst_byte_count", {28'b0, byte_count}, 32'd0);
      chk("rst_running", {31'b0, running}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);

      // Basic decrypt, key 5A
      key_load = 1'b1; key_in = 8'h5A;
      step(1'b0);
      key_load = 1'b0; bif.out_ready = 1'b1; bif.in_valid = 1'b1;
      bif.in_data = 8'h3B; step(1'b1); chk("t1_b0", {24'b0, bif.out_data}, 32'h61);
      bif.in_data = 8'h3C; step(1'b1); chk("t1_b1", {24'b0, bif.out_data}, 32'h61);
      bif.in_data = 8'h00; step(1'b1); chk("t1_b2", {24'b0, bif.out_data}, 32'hA7);
      chk("t1_count", {28'b0, byte_count}, 32'd3);
      bif.in_valid = 1'b0; step(1'b1);

      // Backpressure
      key_load = 1'b1; key_in = 8'h5A; step(1'b0);
      key_load = 1'b0; bif.out_ready = 1'b0; bif.in_valid = 1'b1;
      bif.in_data = 8'h3B; step(1'b1);
      chk("t2_first", {24'b0, bif.out_data}, 32'h61);
      bif.in_data = 8'h3C; step(1'b0); step(1'b0);
      chk("t2_hold_data", {24'b0, bif.out_data}, 32'h61);
      chk("t2_hold_valid", {31'b0, bif.out_valid}, 32'd1);
      chk("t2_stall_count", {28'b0, byte_count}, 32'd1);
      bif.out_ready = 1'b1; step(1'b1);
      chk("t2_second", {24'b0, bif.out_data}, 32'h61);
      bif.in_valid = 1'b0; step(1'b1);

      // Keystream wrap and counter wrap
      key_load = 1'b1; key_in = 8'h00; step(1'b0);
      key_load = 1'b0; bif.in_valid = 1'b1; bif.in_data = 8'h00;
      for (int i = 0; i < 17; i++) begin
         step(1'b1);
         chk($sformatf("t3_b%0d", i), {24'b0, bif.out_data}, {24'b0, t3[i]});
         if (i == 15) chk("t6_count_wrap", {28'b0, byte_count}, 32'd0);
      end
      chk("t6_count_after", {28'b0, byte_count}, 32'd1);
      bif.in_valid = 1'b0; step(1'b1);

      // Re-key collision with pending output
      key_load = 1'b1; key_in = 8'h5A; step(1'b0);
      key_load = 1'b0; bif.out_ready = 1'b0; bif.in_valid = 1'b1; bif.in_data = 8'h3B;
      step(1'b1);
      chk("t4_pending", {24'b0, bif.out_data}, 32'h61);
      key_load = 1'b1; key_in = 8'hFF; bif.out_ready = 1'b1; bif.in_data = 8'h3C;
      step(1'b0);
      chk("t4_drained", {31'b0, bif.out_valid}, 32'd0);
      chk("t4_count0", {28'b0, byte_count}, 32'd0);
      key_load = 1'b0; bif.in_data = 8'h00; step(1'b1);
      chk("t4_newkey", {24'b0, bif.out_data}, 32'hFF);
      chk("t4_count1", {28'b0, byte_count}, 32'd1);
      bif.in_valid = 1'b0; step(1'b1);

      // Reset mid-operation
      bif.out_ready = 1'b0; bif.in_valid = 1'b1; bif.in_data = 8'h3B; step(1'b1);
      chk("t5_pre_valid", {31'b0, bif.out_valid}, 32'd1);
      rst_n = 1'b1; step(1'b0);
      rst_n = 1'b0;
      chk("t5_out_valid", {31'b0, bif.out_valid}, 32'd0);
      bif.in_data = 8'h3C; bif.out_ready = 1'b1;
      repeat (3) step(1'b0);
      chk("t5_no_accept", {31'b0, bif.out_valid}, 32'd0);
      chk("t5_count", {28'b0, byte_count}, 32'd0);
      bif.in_valid = 1'b0;

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
